// File: rtl/steady_detector_if.sv
// Bundle between the simulator controlpath/datapath and the steady-state detector.
// The master drives rule updates and control strobes; the slave reports coverage and convergence.
interface steady_detector_if #(
    parameter int unsigned NUM_ELEM   = 16,
    parameter int unsigned LOG_ELEM   = 4,
    parameter int unsigned LOG_ROUNDS = 2
);
    logic                  validRule;
    logic [LOG_ELEM-1:0]   rule_idx;
    logic [NUM_ELEM-1:0]   cur_state;
    logic                  ld_updated;
    logic                  clr_updated;
    logic                  ld_last_state;
    logic                  is_steady_state;
    logic                  steady;
    logic [NUM_ELEM-1:0]   updated;
    logic [LOG_ROUNDS-1:0] quiet_rounds;
    logic                  bad_idx;

    modport master (
        output validRule, rule_idx, cur_state, ld_updated, clr_updated, ld_last_state,
        input  is_steady_state, steady, updated, quiet_rounds, bad_idx
    );

    modport slave (
        input  validRule, rule_idx, cur_state, ld_updated, clr_updated, ld_last_state,
        output is_steady_state, steady, updated, quiet_rounds, bad_idx
    );
endinterface

// File: rtl/steady_detector.sv
// Tracks rule coverage per round and state changes; pulses on each completed round and
// raises steady once STEADY_ROUNDS consecutive rounds finish without any state change.
module steady_detector #(
    parameter int unsigned NUM_ELEM      = 16,
    parameter int unsigned LOG_ELEM      = 4,
    parameter int unsigned STEADY_ROUNDS = 2,
    parameter int unsigned LOG_ROUNDS    = 2
) (
    input logic              clk,
    input logic              rst,
    steady_detector_if.slave bus
);
    // One extra bit so NUM_ELEM == 2**LOG_ELEM does not truncate to zero.
    localparam logic [LOG_ELEM:0]     NumElemW  = (LOG_ELEM + 1)'(NUM_ELEM);
    localparam logic [LOG_ROUNDS-1:0] SatRounds = LOG_ROUNDS'(STEADY_ROUNDS);
    localparam logic [NUM_ELEM-1:0]   AllOnes   = '1;

    logic [NUM_ELEM-1:0]   updated_q, updated_d;
    logic [NUM_ELEM-1:0]   last_state_q, last_state_d;
    logic                  round_changed_q, round_changed_d;
    logic [LOG_ROUNDS-1:0] quiet_q, quiet_d;
    logic                  steady_q, steady_d;
    logic                  pulse_q;
    logic                  bad_q, bad_d;

    logic                  in_range, upd, chg, done;
    logic [NUM_ELEM-1:0]   onehot;

    always_comb begin
        in_range = {1'b0, bus.rule_idx} < NumElemW;
        upd      = bus.validRule & bus.ld_updated & in_range;
        bad_d    = bad_q | (bus.validRule & bus.ld_updated & ~in_range);
        onehot   = NUM_ELEM'(1) << bus.rule_idx;
        chg      = bus.validRule & bus.ld_last_state & (bus.cur_state != last_state_q);

        last_state_d = last_state_q;
        if (bus.validRule && bus.ld_last_state) begin
            last_state_d = bus.cur_state;
        end

        // An update landing with the clear opens the new round instead of being dropped.
        updated_d = updated_q;
        if (bus.clr_updated) begin
            updated_d = upd ? onehot : '0;
        end else if (upd) begin
            updated_d = updated_q | onehot;
        end

        round_changed_d = bus.clr_updated ? chg : (round_changed_q | chg);

        done = (updated_d == AllOnes) & (updated_q != AllOnes) & ~bus.clr_updated;

        quiet_d = quiet_q;
        if (done) begin
            if (round_changed_q || chg) begin
                quiet_d = '0;
            end else if (quiet_q < SatRounds) begin
                quiet_d = quiet_q + 1'b1;
            end
        end else if (chg) begin
            quiet_d = '0;
        end

        // Clear beats set when a change coincides with the qualifying round.
        steady_d = steady_q | (done & (quiet_d == SatRounds));
        if (chg) begin
            steady_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            updated_q       <= '0;
            last_state_q    <= '0;
            round_changed_q <= 1'b0;
            quiet_q         <= '0;
            steady_q        <= 1'b0;
            pulse_q         <= 1'b0;
            bad_q           <= 1'b0;
        end else begin
            updated_q       <= updated_d;
            last_state_q    <= last_state_d;
            round_changed_q <= round_changed_d;
            quiet_q         <= quiet_d;
            steady_q        <= steady_d;
            pulse_q         <= done;
            bad_q           <= bad_d;
        end
    end

    assign bus.updated         = updated_q;
    assign bus.quiet_rounds    = quiet_q;
    assign bus.steady          = steady_q;
    assign bus.is_steady_state = pulse_q;
    assign bus.bad_idx         = bad_q;
endmodule

// File: tb/tb_steady_detector.sv
// Directed bench for steady_detector with NUM_ELEM=4, STEADY_ROUNDS=2.
module tb_steady_detector;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    steady_detector_if #(.NUM_ELEM(4), .LOG_ELEM(3), .LOG_ROUNDS(2)) sd_if ();

    steady_detector #(
        .NUM_ELEM(4),
        .LOG_ELEM(3),
        .STEADY_ROUNDS(2),
        .LOG_ROUNDS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sd_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then land 1 time unit past the capturing edge.
    task automatic apply(input logic v, input logic [2:0] idx, input logic [3:0] st,
                         input logic ldu, input logic clr, input logic ldl);
        sd_if.validRule     = v;
        sd_if.rule_idx      = idx;
        sd_if.cur_state     = st;
        sd_if.ld_updated    = ldu;
        sd_if.clr_updated   = clr;
        sd_if.ld_last_state = ldl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
            outs = {sd_if.is_steady_state, sd_if.steady, sd_if.updated, sd_if.quiet_rounds,
                    sd_if.bad_idx};
            checks++;
            if (outs !== 9'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b want 000000000", i, outs);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle();
            outs = {sd_if.is_steady_state, sd_if.steady, sd_if.updated, sd_if.quiet_rounds,
                    sd_if.bad_idx};
            checks++;
            if (outs !== 9'd0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %b want 000000000", i, outs);
            end
        end
    endtask

    task automatic test_coverage();
        logic [2:0] idxs  [5] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
        logic [3:0] masks [5] = '{4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b1111};
        logic       pulses[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, idxs[i], 4'b0000, 1'b1, 1'b0, 1'b1);
            checks++;
            if (sd_if.updated !== masks[i]) begin
                errors++;
                $display("FAIL cov_mask[%0d]: got %b want %b", i, sd_if.updated, masks[i]);
            end
            checks++;
            if (sd_if.is_steady_state !== pulses[i]) begin
                errors++;
                $display("FAIL cov_pulse[%0d]: got %b want %b", i, sd_if.is_steady_state,
                         pulses[i]);
            end
        end
        apply(1'b1, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sd_if.is_steady_state !== 1'b0 || sd_if.updated !== 4'b1111) begin
            errors++;
            $display("FAIL cov_repeat: got pulse=%b mask=%b want pulse=0 mask=1111",
                     sd_if.is_steady_state, sd_if.updated);
        end
        idle();
        checks++;
        if (sd_if.is_steady_state !== 1'b0) begin
            errors++;
            $display("FAIL cov_idle: got pulse=%b want 0", sd_if.is_steady_state);
        end
    endtask

    task automatic test_convergence();
        logic [3:0] r1_st[4] = '{4'b0000, 4'b0101, 4'b0101, 4'b0101};
        do_reset();
        for (int i = 0; i < 4; i++) apply(1'b1, 3'(i), r1_st[i], 1'b1, 1'b0, 1'b1);
        checks++;
        if ({sd_if.is_steady_state, sd_if.quiet_rounds, sd_if.steady} !== 4'b1000) begin
            errors++;
            $display("FAIL conv_r1: got pulse=%b quiet=%0d steady=%b want 1,0,0",
                     sd_if.is_steady_state, sd_if.quiet_rounds, sd_if.steady);
        end
        for (int r = 2; r <= 3; r++) begin
            apply(1'b0, 3'd0, 4'b0101, 1'b0, 1'b1, 1'b0);
            checks++;
            if (sd_if.updated !== 4'b0000 || sd_if.is_steady_state !== 1'b0) begin
                errors++;
                $display("FAIL conv_clr_r%0d: got mask=%b pulse=%b want 0000,0", r,
                         sd_if.updated, sd_if.is_steady_state);
            end
            for (int i = 0; i < 4; i++) apply(1'b1, 3'(i), 4'b0101, 1'b1, 1'b0, 1'b1);
            checks++;
            if (sd_if.is_steady_state !== 1'b1 || sd_if.quiet_rounds !== 2'(r - 1)
                || sd_if.steady !== (r == 3)) begin
                errors++;
                $display("FAIL conv_r%0d: got pulse=%b quiet=%0d steady=%b want 1,%0d,%0d",
                         r, sd_if.is_steady_state, sd_if.quiet_rounds, sd_if.steady, r - 1,
                         (r == 3));
            end
        end
        apply(1'b0, 3'd0, 4'b0101, 1'b0, 1'b1, 1'b0);
        checks++;
        if (sd_if.steady !== 1'b1 || sd_if.quiet_rounds !== 2'd2) begin
            errors++;
            $display("FAIL conv_hold: got steady=%b quiet=%0d want 1,2", sd_if.steady,
                     sd_if.quiet_rounds);
        end
    endtask

    task automatic test_steady_drop();
        apply(1'b1, 3'd0, 4'b0100, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({sd_if.steady, sd_if.quiet_rounds, sd_if.updated} !== 7'b0_00_0001) begin
            errors++;
            $display("FAIL drop: got steady=%b quiet=%0d mask=%b want 0,0,0001",
                     sd_if.steady, sd_if.quiet_rounds, sd_if.updated);
        end
    endtask

    task automatic test_clr_with_update();
        apply(1'b1, 3'd2, 4'b0101, 1'b1, 1'b1, 1'b1);
        checks++;
        if (sd_if.updated !== 4'b0100) begin
            errors++;
            $display("FAIL clr_upd_mask: got %b want 0100", sd_if.updated);
        end
        apply(1'b1, 3'd0, 4'b0101, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 3'd1, 4'b0101, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sd_if.updated !== 4'b0111 || sd_if.is_steady_state !== 1'b0) begin
            errors++;
            $display("FAIL clr_upd_fill: got mask=%b pulse=%b want 0111,0", sd_if.updated,
                     sd_if.is_steady_state);
        end
        // Change seen in the clear cycle must keep this round from counting as quiet.
        apply(1'b1, 3'd3, 4'b0101, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sd_if.is_steady_state !== 1'b1 || sd_if.quiet_rounds !== 2'd0) begin
            errors++;
            $display("FAIL clr_upd_round: got pulse=%b quiet=%0d want 1,0",
                     sd_if.is_steady_state, sd_if.quiet_rounds);
        end
    endtask

    task automatic test_bad_idx_reset();
        logic [8:0] outs;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) apply(1'b1, 3'(i), 4'b0000, 1'b1, 1'b0, 1'b1);
            apply(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) apply(1'b1, 3'(i), 4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sd_if.steady !== 1'b1 || sd_if.updated !== 4'b0111 || sd_if.bad_idx !== 1'b0) begin
            errors++;
            $display("FAIL bad_setup: got steady=%b mask=%b bad=%b want 1,0111,0",
                     sd_if.steady, sd_if.updated, sd_if.bad_idx);
        end
        apply(1'b1, 3'd5, 4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sd_if.bad_idx !== 1'b1 || sd_if.updated !== 4'b0111 || sd_if.steady !== 1'b1) begin
            errors++;
            $display("FAIL bad_idx: got bad=%b mask=%b steady=%b want 1,0111,1",
                     sd_if.bad_idx, sd_if.updated, sd_if.steady);
        end
        idle();
        checks++;
        if (sd_if.bad_idx !== 1'b1) begin
            errors++;
            $display("FAIL bad_sticky: got %b want 1", sd_if.bad_idx);
        end
        rst = 1'b1;
        apply(1'b1, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b1);
        outs = {sd_if.is_steady_state, sd_if.steady, sd_if.updated, sd_if.quiet_rounds,
                sd_if.bad_idx};
        checks++;
        if (outs !== 9'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %b want 000000000", outs);
        end
        rst = 1'b0;
        idle();
        outs = {sd_if.is_steady_state, sd_if.steady, sd_if.updated, sd_if.quiet_rounds,
                sd_if.bad_idx};
        checks++;
        if (outs !== 9'd0) begin
            errors++;
            $display("FAIL midrun_after: got %b want 000000000", outs);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        sd_if.validRule     = 1'b0;
        sd_if.rule_idx      = '0;
        sd_if.cur_state     = '0;
        sd_if.ld_updated    = 1'b0;
        sd_if.clr_updated   = 1'b0;
        sd_if.ld_last_state = 1'b0;
        test_reset();
        test_coverage();
        test_convergence();
        test_steady_drop();
        test_clr_with_update();
        test_bad_idx_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/steady_detector.md
Name: steady_detector

Overview:
- Tracks rule-update coverage and state changes for the random-order asynchronous simulator; sits directly upstream of the simulation controlpath.
- Consumes that controlpath's ld_updated, clr_updated and ld_last_state, together with the rule index and post-update network state from the datapath.
- Produces is_steady_state, a round-complete pulse that the controlpath turns into clr_updated.
- Produces steady, the converged flag the controlpath forwards as steady_state.

Parameters:
NUM_ELEM, 16, number of network elements / rules
LOG_ELEM, 4, width of rule index; 2**LOG_ELEM >= NUM_ELEM
STEADY_ROUNDS, 2, consecutive change-free full rounds required to declare steady (>=1)
LOG_ROUNDS, 2, width of quiet_rounds; 2**LOG_ROUNDS > STEADY_ROUNDS

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
validRule  in  1  rule_idx/cur_state valid this cycle
rule_idx  in  LOG_ELEM  index of rule applied this cycle
cur_state  in  NUM_ELEM  network state after this cycle's update
ld_updated  in  1  record rule_idx in coverage mask
clr_updated  in  1  clear coverage mask / round change flag
ld_last_state  in  1  capture cur_state as comparison baseline
is_steady_state  out  1  one-cycle pulse: coverage round completed
steady  out  1  level: STEADY_ROUNDS change-free rounds seen
updated  out  NUM_ELEM  coverage mask
quiet_rounds  out  LOG_ROUNDS  consecutive change-free round count (saturating)
bad_idx  out  1  sticky: valid update with rule_idx >= NUM_ELEM

Behaviour:
- Reset: updated=0, last_state=0, round_changed=0, quiet_rounds=0, steady=0, is_steady_state=0, bad_idx=0. Reset mid-operation discards everything; no pulse is emitted.
- Valid update (upd): validRule & ld_updated & (rule_idx < NUM_ELEM).
- Out-of-range index:
  - rule_idx >= NUM_ELEM with validRule & ld_updated sets bad_idx, cleared only by rst.
  - The mask is not modified.
  - Change detection still applies.
- Change detection: chg = validRule & ld_last_state & (cur_state != last_state). On validRule & ld_last_state, last_state <= cur_state.
  - The first compare after reset is against 0 and may flag a change. This is intended.
- Coverage mask next value (mask_n):
  - clr_updated only: 0.
  - clr_updated & upd: onehot(rule_idx). The update is counted in the new round and is not lost.
  - upd only: updated | onehot(rule_idx).
  - Otherwise: hold.
- Round change flag:
  - clr_updated: round_changed <= chg.
  - Otherwise: round_changed <= round_changed | chg.
- Round completion (done):
  - done = (mask_n == all-ones) & (updated != all-ones) & ~clr_updated.
  - done fires only on the transition to full; re-updating a covered rule does not re-fire it.
- is_steady_state: registered. It is high exactly one cycle after the completing update, and low otherwise. The controlpath's clr_updated response arrives in that pulse cycle.
- quiet_rounds on done:
  - If round_changed | chg: quiet_rounds <= 0.
  - Else: quiet_rounds <= min(quiet_rounds+1, STEADY_ROUNDS).
- quiet_rounds outside done: any chg forces quiet_rounds <= 0. clr_updated alone does not alter quiet_rounds.
- steady:
  - Set (registered) when quiet_rounds reaches STEADY_ROUNDS; visible the cycle after the qualifying done, together with the pulse.
  - Cleared on the edge following any chg.
  - If set and clear coincide, clear wins.
- Latency:
  - update -> updated bit: 1 cycle.
  - completing update -> is_steady_state: 1 cycle.
  - chg -> steady low: 1 cycle.
- No backpressure. Inputs are sampled every cycle; validRule=0 cycles change nothing.

Test Plan:
Use NUM_ELEM=4, STEADY_ROUNDS=2 for all scenarios.
- Reset values: hold rst 3 cycles with random inputs -> all outputs 0; release -> still 0 until first valid update.
- Coverage and single pulse: updates with cur_state=0 constant, rule_idx 0,1,1,2,3 -> updated 0001,0011,0011,0111,1111; is_steady_state high once, one cycle after idx 3; repeating idx 3 gives no second pulse.
- Convergence:
  - Round 1 has cur_state change 0000->0101 -> quiet_rounds=0.
  - Rounds 2 and 3 have constant state, with clr_updated asserted in each pulse cycle -> quiet_rounds 1 then 2; steady=1 the cycle after round 3's completing update.
- Steady drop: while steady=1, apply update with cur_state 0101->0100 -> steady=0 and quiet_rounds=0 the next cycle; updated mask unaffected.
- Simultaneous clr and update: clr_updated=1 with upd idx 2 in same cycle -> updated=0100 (not 0000); a chg in that cycle makes round_changed=1 for the new round.
- Bad index and mid-run reset:
  - rule_idx=5 with validRule & ld_updated -> bad_idx=1 sticky, mask unchanged.
  - Assert rst with updated=0111 and steady=1 -> next cycle all 0, no pulse.
